tomasulo_regfile: RTL
=====================

Name: tomasulo_regfile

Overview:
Parametrised architectural register file with per-register rename status (busy bit + producer tag) for the dynamically scheduled pipeline. Issue stage reads NUM_RD source operands and gets either a ready value or the tag of the in-flight producer. Issue also claims the destination register with a new tag. A common data bus (CDB) broadcast writes results back to every register still waiting on that tag; flush clears all pending renames.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
TAG_W, 4, reservation-station/producer tag width
NUM_RD, 2, number of combinational read ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
issue_en  in  1  claim destination register this cycle
issue_rd  in  ADDR_W  destination register being claimed
issue_tag  in  TAG_W  producer tag assigned to issue_rd
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  tag of broadcasting producer
cdb_data  in  DATA_W  result value
flush  in  1  discard all pending renames
rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read value per port
rd_busy  out  NUM_RD  1 = value not ready; use rd_tag
rd_tag  out  NUM_RD*TAG_W  producer tag per port, 0 when not busy
busy_count  out  ADDR_W+1  registered count of busy registers
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  raw stored value of dbg_addr, no bypass

Behaviour:
- Reset (async): all data = 0, busy = 0, tags = 0, busy_count = 0. While rst is high, all read outputs = 0.
- Register 0: always reads data 0, busy 0, tag 0. Issue to r0 is ignored. r0 never counts in busy_count.
- Reads are combinational, per port k, in priority order:
  - addr 0 -> 0 / not busy.
  - Register busy && cdb_valid && tag match -> rd_data = cdb_data, busy 0, tag 0 (same-cycle CDB bypass).
  - Register busy -> rd_data = stored data, rd_busy = 1, rd_tag = stored tag.
  - Otherwise -> stored data, busy 0, tag 0.
- Reads always see pre-issue state. An instruction whose source equals its own destination gets the old producer, not itself.
- Clocked update, no flush:
  - CDB: every register with busy && tag == cdb_tag gets data = cdb_data and busy cleared. Several registers may match in one cycle.
  - Issue: issue_rd gets busy = 1 and tag = issue_tag. Data is unchanged.
  - Issue and CDB on the same register in the same cycle: the CDB data write still happens, then issue's busy/tag take precedence. The register ends with the new value, busy = 1, and the new tag.
  - Issue to an already-busy register overwrites the tag. A later CDB with the old tag no longer writes it.
  - A CDB tag matching no busy register has no effect.
- Flush (highest priority): all busy = 0, all tags = 0. Issue and CDB in the same cycle are ignored. Data is unchanged. busy_count becomes 0 next cycle.
- busy_count is updated every edge to the popcount of busy bits after the update. One-cycle latency relative to the causing event.
- No X propagation: out-of-range addresses cannot occur; all DEPTH entries are implemented.

Test Plan:
- Reset mid-operation: issue r3 tag 5, then assert rst asynchronously -> immediately all reads 0, busy 0, busy_count 0; r3 data 0 after release.
- Issue r4 tag 2, next cycle read r4 -> busy 1, tag 2, busy_count 1. Then cdb_valid tag 2 data 0xDEADBEEF -> same-cycle read of r4 returns 0xDEADBEEF, busy 0. Next cycle dbg_data(r4) = 0xDEADBEEF, busy_count 0.
- Issue r5 tag 1 and r6 tag 1 on consecutive cycles, then CDB tag 1 data 0x55 -> both r5 and r6 = 0x55, not busy, busy_count 2 -> 0.
- Same-cycle issue r7 tag 3 with CDB matching r7's old tag 1, data 0x11 -> dbg_data(r7) = 0x11, r7 busy 1 tag 3. Later CDB tag 1 data 0x99 -> r7 unchanged.
- Issue r0 tag 4, then CDB tag 4 data 0x77 -> r0 reads 0, never busy, busy_count 0.
- Issue r1, r2, r3 (tags 1, 2, 3), busy_count 3. Then flush together with CDB tag 2 and issue r9 -> all not busy, r2 data unchanged, r9 not busy, busy_count 0.

Source files
------------

// File: rtl/tomasulo_regfile.sv
// Purpose: architectural register file with per-register rename state (busy + producer tag), CDB writeback and flush.
// Latency: reads are combinational with same-cycle CDB bypass; writes, renames and busy_count take effect at the next clk edge.
// Backpressure: none; issue, CDB and flush are accepted every cycle, and flush overrides issue and CDB.
module tomasulo_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 4,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_rd,
    input  logic [TAG_W-1:0]         issue_tag,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [DATA_W-1:0]        cdb_data,
    input  logic                     flush,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [NUM_RD*TAG_W-1:0]  rd_tag,
    output logic [ADDR_W:0]          busy_count,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DEPTH-1:0]  cdb_hit;
    logic [ADDR_W:0]   count_d;
    logic              issue_ok;

    // r0 is hardwired, so a claim on it is simply dropped
    assign issue_ok = issue_en && (issue_rd != '0);

    // Registers waiting on the broadcasting tag; r0 can never be waiting
    always_comb begin
        cdb_hit = '0;
        for (int i = 1; i < DEPTH; i++) begin
            cdb_hit[i] = cdb_valid && busy_q[i] && (tag_q[i] == cdb_tag);
        end
    end

    // Next busy vector: flush wins, else CDB clears and issue sets (issue last so it wins on the same register)
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            busy_d = busy_q & ~cdb_hit;
            if (issue_ok) begin
                busy_d[issue_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Popcount of the post-update busy vector, registered as busy_count
    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    // Data array: CDB writes every matching register; flush drops the broadcast
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_hit[i]) begin
                    data_q[i] <= cdb_data;
                end
            end
        end
    end

    // Tag array: flush clears everything, issue stamps the new producer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else if (issue_ok) begin
            tag_q[issue_rd] <= issue_tag;
        end
    end

    // Busy vector and its registered population count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_count <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_count <= count_d;
        end
    end

    // Read ports see pre-issue state, with a same-cycle bypass from the CDB
    always_comb begin
        logic [ADDR_W-1:0] a;
        a       = '0;
        rd_data = '0;
        rd_busy = '0;
        rd_tag  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a = rd_addr[k*ADDR_W +: ADDR_W];
            if (!rst && (a != '0)) begin
                if (cdb_hit[a]) begin
                    rd_data[k*DATA_W +: DATA_W] = cdb_data;
                end else if (busy_q[a]) begin
                    rd_data[k*DATA_W +: DATA_W] = data_q[a];
                    rd_busy[k]                  = 1'b1;
                    rd_tag[k*TAG_W +: TAG_W]    = tag_q[a];
                end else begin
                    rd_data[k*DATA_W +: DATA_W] = data_q[a];
                end
            end
        end
    end

    // Debug port shows the raw stored value, without the CDB bypass
    assign dbg_data = rst ? '0 : data_q[dbg_addr];

endmodule
